// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - Requester and SRAM-controller signal bundle for sram_arbiter
interface sram_arbiter_if #(
    parameter int NUM_REQ = 5
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_we_n;
    logic [NUM_REQ*18-1:0] req_address;
    logic [NUM_REQ*16-1:0] req_write_data;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rd_valid;
    logic [15:0]           rd_data;
    logic [17:0]           SRAM_address_o;
    logic [15:0]           SRAM_write_data_o;
    logic                  SRAM_we_n_o;
    logic [15:0]           SRAM_read_data;
    logic [2:0]            owner_id;

    modport slave (
        input  req, req_we_n, req_address, req_write_data, SRAM_read_data,
        output gnt, rd_valid, rd_data, SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o, owner_id
    );

    modport master (
        output req, req_we_n, req_address, req_write_data, SRAM_read_data,
        input  gnt, rd_valid, rd_data, SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o, owner_id
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - SRAM port arbiter: VGA absolute priority, round-robin with burst limit
// for the other units, and read-owner tagging across the SRAM pipeline delay.
module sram_arbiter #(
    parameter int NUM_REQ      = 5,
    parameter int READ_LATENCY = 3,
    parameter int MAX_BURST    = 64
) (
    input  logic          Clock,
    input  logic          Resetn,
    sram_arbiter_if.slave bus
);
    localparam int         BW       = $clog2(MAX_BURST + 1);
    localparam logic [2:0] NO_OWNER = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [2:0]         owner_q;
    logic [2:0]         ptr_q;
    logic [BW-1:0]      burst_q;
    logic [NUM_REQ-1:0] tag_q [READ_LATENCY];

    logic [NUM_REQ-1:0] access;
    logic [2:0]         win_idx;
    logic               any_req;
    logic               others_req;
    logic               leave;
    logic               burst_full;

    assign access     = gnt_q & bus.req;
    assign any_req    = |bus.req;
    assign others_req = |(bus.req & ~gnt_q);
    assign burst_full = (burst_q == BW'(MAX_BURST - 1));

    // Port 0 wins outright; otherwise scan ports 1..NUM_REQ-1 starting just after the pointer.
    always_comb begin
        int         p;
        logic [2:0] p3;
        win_idx = 3'd0;
        p       = 0;
        p3      = 3'd0;
        if (!bus.req[0]) begin
            for (int k = NUM_REQ - 1; k >= 1; k--) begin
                p = int'(ptr_q) + k;
                if (p > NUM_REQ - 1) begin
                    p = p - (NUM_REQ - 1);
                end
                p3 = 3'(p);
                if (bus.req[p3]) begin
                    win_idx = p3;
                end
            end
        end
    end

    always_comb begin
        leave = 1'b0;
        if (!(|access)) begin
            leave = 1'b1;
        end else if (!gnt_q[0] && (bus.req[0] || (burst_full && others_req))) begin
            leave = 1'b1;
        end
    end

    always_comb begin
        bus.SRAM_address_o    = '0;
        bus.SRAM_write_data_o = '0;
        bus.SRAM_we_n_o       = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (access[i]) begin
                bus.SRAM_address_o    = bus.req_address[18*i +: 18];
                bus.SRAM_write_data_o = bus.req_write_data[16*i +: 16];
                bus.SRAM_we_n_o       = bus.req_we_n[i];
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= NO_OWNER;
            ptr_q   <= 3'(NUM_REQ - 1);
            burst_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            // Tags shift independently of ownership so preempted reads still reach their owner.
            tag_q[0] <= access & bus.req_we_n;
            for (int k = 1; k < READ_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            case (state_q)
                S_IDLE, S_TURN: begin
                    if (any_req) begin
                        state_q <= S_OWN;
                        gnt_q   <= NUM_REQ'(1) << win_idx;
                        owner_q <= win_idx;
                        burst_q <= '0;
                        if (win_idx != 3'd0) begin
                            ptr_q <= win_idx;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                        owner_q <= NO_OWNER;
                    end
                end
                S_OWN: begin
                    if (leave) begin
                        state_q <= S_TURN;
                        gnt_q   <= '0;
                        owner_q <= NO_OWNER;
                    end else if (!gnt_q[0] && !burst_full) begin
                        burst_q <= burst_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    owner_q <= NO_OWNER;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.owner_id = owner_q;
    assign bus.rd_valid = tag_q[READ_LATENCY-1];
    assign bus.rd_data  = bus.SRAM_read_data;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - Randomized bench for sram_arbiter against an ownership/read-queue model
module tb_sram_arbiter;
    localparam int N  = 5;
    localparam int RL = 3;
    localparam int MB = 4;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    always #10 Clock = ~Clock;

    sram_arbiter_if #(.NUM_REQ(N)) bus ();

    sram_arbiter #(.NUM_REQ(N), .READ_LATENCY(RL), .MAX_BURST(MB)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    // SRAM stand-in: returns address+0x1000 three cycles after the address is presented.
    logic [17:0] ap0 = '0, ap1 = '0, ap2 = '0;
    always @(negedge Clock) begin
        ap0 <= bus.SRAM_address_o;
        ap1 <= ap0;
        ap2 <= ap1;
    end
    assign bus.SRAM_read_data = ap2[15:0] + 16'h1000;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          due;
        int          port;
        logic [15:0] data;
    } rd_t;

    rd_t rq[$];
    int  m_owner = -1;
    int  m_ptr   = N - 1;
    int  m_cnt   = 0;
    int  cyc     = 0;

    function automatic int pick_winner(input logic [N-1:0] r, input int ptr);
        if (r[0]) return 0;
        for (int k = 1; k < N; k++) begin
            int p;
            p = (ptr - 1 + k) % (N - 1) + 1;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_cnt   = 0;
        cyc     = 0;
        rq.delete();
    endtask

    task automatic model_step();
        logic [N-1:0] others;
        rd_t          e;
        if (m_owner >= 0 && bus.req[m_owner] && bus.req_we_n[m_owner]) begin
            e.due  = cyc + RL;
            e.port = m_owner;
            e.data = bus.req_address[18*m_owner +: 16] + 16'h1000;
            rq.push_back(e);
        end
        if (m_owner < 0) begin
            if (bus.req != '0) begin
                m_owner = pick_winner(bus.req, m_ptr);
                m_cnt   = 0;
                if (m_owner != 0) m_ptr = m_owner;
            end
        end else begin
            others = bus.req & ~(N'(1) << m_owner);
            if (!bus.req[m_owner] || (m_owner != 0 && (bus.req[0] || (m_cnt == MB - 1 && others != '0))))
                m_owner = -1;
            else if (m_owner != 0 && m_cnt < MB - 1)
                m_cnt++;
        end
        cyc++;
    endtask

    task automatic compare();
        logic [N-1:0] e_gnt, e_rv;
        logic [2:0]   e_own;
        logic         e_we;
        logic [17:0]  e_addr;
        logic [15:0]  e_wd, e_rd;
        bit           rd_chk;
        e_gnt = '0; e_rv = '0; e_own = 3'd7; e_we = 1'b1;
        e_addr = '0; e_wd = '0; e_rd = '0; rd_chk = 0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_own          = 3'(m_owner);
            if (bus.req[m_owner]) begin
                e_we   = bus.req_we_n[m_owner];
                e_addr = bus.req_address[18*m_owner +: 18];
                e_wd   = bus.req_write_data[16*m_owner +: 16];
            end
        end
        while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e_rv[rq[0].port] = 1'b1;
            e_rd             = rq[0].data;
            rd_chk           = 1;
        end
        chk("gnt", 32'(bus.gnt), 32'(e_gnt));
        chk("owner_id", 32'(bus.owner_id), 32'(e_own));
        chk("we_n", 32'(bus.SRAM_we_n_o), 32'(e_we));
        chk("address", 32'(bus.SRAM_address_o), 32'(e_addr));
        chk("wdata", 32'(bus.SRAM_write_data_o), 32'(e_wd));
        chk("rd_valid", 32'(bus.rd_valid), 32'(e_rv));
        if (rd_chk) chk("rd_data", 32'(bus.rd_data), 32'(e_rd));
    endtask

    initial begin
        forever begin
            @(posedge Clock or negedge Clock or negedge Resetn);
            if (!Resetn) model_reset();
            else if (Clock) model_step();
            if (!Clock) compare();
        end
    end

    bit rnd_on = 1'b0;
    bit rnd_we = 1'b0;

    task automatic step();
        @(posedge Clock);
        #1;
        if (rnd_on) begin
            for (int i = 0; i < N; i++) begin
                bus.req_address[18*i +: 18]    = 18'($urandom);
                bus.req_write_data[16*i +: 16] = 16'($urandom);
                if (rnd_we) bus.req_we_n[i] = 1'($urandom);
            end
        end
    endtask

    task automatic tick();
        step();
        @(negedge Clock);
    endtask

    task automatic drain();
        step();
        bus.req = '0;
        repeat (5) tick();
    endtask

    task automatic wait_gnt(input logic [N-1:0] g, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (bus.gnt == g) found = 1;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    int rot_exp [15] = '{1, 1, 1, 7, 3, 3, 3, 3, 7, 4, 4, 4, 4, 7, 1};

    initial begin
        bus.req            = '1;
        bus.req_we_n       = '1;
        bus.req_address    = '0;
        bus.req_write_data = '0;
        rnd_on = 1'b1;
        rnd_we = 1'b0;

        repeat (3) tick();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_we_n", 32'(bus.SRAM_we_n_o), 32'd1);
        chk("rst_owner", 32'(bus.owner_id), 32'd7);
        step();
        Resetn = 1'b1;
        @(negedge Clock);
        chk("rel_gnt_pre", 32'(bus.gnt), 32'd0);
        tick();
        chk("rel_gnt", 32'(bus.gnt), 32'b00001);
        chk("rel_owner", 32'(bus.owner_id), 32'd0);

        drain();
        step();
        bus.req = 5'b11010;
        wait_gnt(5'b00010, "rot_start");
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("rot_seq", 32'(bus.owner_id), 32'(rot_exp[i]));
        end

        drain();
        step();
        bus.req_we_n = '1;
        bus.req      = 5'b00100;
        wait_gnt(5'b00100, "pre_start");
        tick();
        tick();
        step();
        bus.req = 5'b00101;
        @(negedge Clock);
        chk("pre_hold", 32'(bus.gnt), 32'b00100);
        tick();
        chk("pre_drop", 32'(bus.gnt), 32'd0);
        chk("pre_rv_a", 32'(bus.rd_valid), 32'b00100);
        tick();
        chk("pre_vga", 32'(bus.gnt), 32'b00001);
        chk("pre_rv_b", 32'(bus.rd_valid), 32'b00100);
        tick();
        chk("pre_rv_c", 32'(bus.rd_valid), 32'b00100);

        drain();
        rnd_on = 1'b0;
        step();
        bus.req_we_n                = '1;
        bus.req_address[18*1 +: 18] = 18'd100;
        bus.req                     = 5'b00010;
        wait_gnt(5'b00010, "rd3_start");
        step();
        bus.req_address[18*1 +: 18] = 18'd101;
        @(negedge Clock);
        step();
        bus.req_address[18*1 +: 18] = 18'd102;
        @(negedge Clock);
        step();
        bus.req = '0;
        @(negedge Clock);
        chk("rd3_v0", 32'(bus.rd_valid), 32'b00010);
        chk("rd3_d0", 32'(bus.rd_data), 32'h1064);
        tick();
        chk("rd3_v1", 32'(bus.rd_valid), 32'b00010);
        chk("rd3_d1", 32'(bus.rd_data), 32'h1065);
        tick();
        chk("rd3_v2", 32'(bus.rd_valid), 32'b00010);
        chk("rd3_d2", 32'(bus.rd_data), 32'h1066);
        tick();
        chk("rd3_v3", 32'(bus.rd_valid), 32'd0);

        drain();
        rnd_on = 1'b1;
        step();
        bus.req_we_n = 5'b01111;
        bus.req      = 5'b10000;
        wait_gnt(5'b10000, "wr_start");
        for (int i = 0; i < 200; i++) begin
            tick();
            chk("wr_gnt", 32'(bus.gnt), 32'b10000);
            chk("wr_we_n", 32'(bus.SRAM_we_n_o), 32'd0);
            chk("wr_rv", 32'(bus.rd_valid), 32'd0);
        end

        drain();
        step();
        bus.req_we_n = '1;
        bus.req      = 5'b01000;
        wait_gnt(5'b01000, "rst_mid_start");
        tick();
        step();
        Resetn = 1'b0;
        @(negedge Clock);
        tick();
        step();
        Resetn  = 1'b1;
        bus.req = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            chk("rst_mid_rv", 32'(bus.rd_valid), 32'd0);
            chk("rst_mid_owner", 32'(bus.owner_id), 32'd7);
            step();
        end

        rnd_we = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            for (int p = 1; p < N; p++) begin
                if ($urandom_range(0, 7) == 0) bus.req[p] = ~bus.req[p];
            end
            if ($urandom_range(0, 15) == 0) bus.req[0] = ~bus.req[0];
            Resetn = (i % 1000 != 999);
        end
        step();
        Resetn  = 1'b1;
        bus.req = '0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Time-shares the single external SRAM controller port between the VGA, UART, LDD, IDCT and CSC units. It replaces the top-level static case mux on top_state.
- Each requester drives a req/we_n/address/write-data set and receives a registered grant.
- The arbiter tags every granted read so that read data returning after the SRAM pipeline delay is flagged to the correct owner.
- Port 0 (VGA) has absolute priority. Ports 1..N-1 are served round-robin with a burst limit.

Parameters:
- NUM_REQ, 5, number of requesters; index 0=VGA, 1=UART, 2=LDD, 3=IDCT, 4=CSC.
- READ_LATENCY, 3, cycles from address presented at SRAM_address_o to valid SRAM_read_data.
- MAX_BURST, 64, maximum consecutive owned cycles for ports 1..N-1 while another request is pending.

Ports:
- Clock  input  1  system clock (50 MHz)
- Resetn  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-port request, held high while access is wanted
- req_we_n  input  NUM_REQ  per-port write enable, active low
- req_address  input  NUM_REQ*18  flattened per-port addresses; port i at [18*i+17:18*i]
- req_write_data  input  NUM_REQ*16  flattened per-port write data
- gnt  output  NUM_REQ  registered one-hot grant
- rd_valid  output  NUM_REQ  one-hot: SRAM_read_data belongs to a read by this port
- rd_data  output  16  SRAM_read_data passed through combinationally
- SRAM_address_o  output  18  to SRAM controller
- SRAM_write_data_o  output  16  to SRAM controller
- SRAM_we_n_o  output  1  to SRAM controller
- SRAM_read_data  input  16  from SRAM controller
- owner_id  output  3  index of current owner; 7 when there is none

Behaviour:
- Reset values (asynchronous, Resetn=0):
  - state=S_IDLE; gnt=0; rd_valid=0; owner_id=7; burst count=0.
  - Round-robin pointer=NUM_REQ-1, so port 1 is searched first.
  - Tag pipeline cleared.
  - SRAM_we_n_o=1, SRAM_address_o=0, SRAM_write_data_o=0.
- Reset mid-operation: all in-flight tags are dropped, and no rd_valid pulse is issued after reset.
- Access rule:
  - An access occurs in cycle t only if gnt[i]=1 and req[i]=1 in cycle t.
  - In that cycle the SRAM outputs are a combinational mux of port i's req_address, req_write_data and req_we_n.
  - In every other cycle SRAM_we_n_o=1, address=0 and write data=0.
- Arbitration winner in a decision cycle:
  - If req[0]=1, port 0 wins.
  - Otherwise the first requesting port in round-robin order, starting after the pointer, skipping port 0.
- States:
  - S_IDLE: no owner. If any req is high, the winner's gnt is set at the next edge -> S_OWN; the pointer updates to the winner if it is not port 0; burst count=0.
  - S_OWN: the owner keeps gnt while its req stays high. The burst count increments each owned cycle for owners 1..N-1. Go to S_TURN (gnt cleared at the next edge) when any of these holds:
    - the owner drops req;
    - the owner is not port 0 and req[0]=1 (VGA preemption);
    - the owner is not port 0, burst count reaches MAX_BURST-1, and another port requests.
  - If burst count reaches MAX_BURST-1 with no other requester, the count saturates and ownership continues.
  - S_TURN: exactly one turnaround cycle with no grant (we_n=1). Arbitrate as in S_IDLE: gnt to the winner at the next edge -> S_OWN, or -> S_IDLE if no requests.
- Ownership switching:
  - Minimum gap between two different owners is 1 cycle.
  - Port 0 preempting an owner sees gnt[0] two edges after req[0] is sampled.
- Requester obligations:
  - A requester must treat gnt deassertion as loss of access and re-present the same access later.
  - A requester may drop req at any time; a write in a cycle with req=0 is never issued.
- Read tagging:
  - A READ_LATENCY-deep one-hot shift register.
  - Each cycle, push one-hot(i) if an access by port i with we_n=1 occurs; otherwise push 0.
  - rd_valid = pipeline output, so it is asserted exactly READ_LATENCY cycles after the read address cycle.
  - Tags survive grant changes, so a preempted owner still receives its in-flight data.
- Boundary cases:
  - Simultaneous req on all ports: port 0 first.
  - Pointer wrap: after NUM_REQ-1 the search continues from 1.
  - A port whose req drops in the same cycle it is granted: no access; leaves through S_TURN.
  - owner_id tracks gnt (registered).

Test Plan:
- Reset held, req=5'b11111 -> gnt=0, rd_valid=0, SRAM_we_n_o=1. Release reset -> gnt=5'b00001 one edge after the first sampled req.
- Ports 1,3,4 request continuously with MAX_BURST=4 and port 0 idle -> owners rotate 1,3,4,1: each owns 4 cycles, with a 1-cycle gap (we_n=1) between owners.
- Port 2 is mid-burst when req[0] rises -> gnt[2] drops at the next edge, then 1 turnaround cycle, then gnt[0]=1. Port 2's reads issued before the drop still produce rd_valid[2] 3 cycles after each read address.
- Port 1 reads addresses 100,101,102 back-to-back, with SRAM model data = address+0x1000 -> rd_valid[1] high 3 cycles later for 3 consecutive cycles, rd_data=0x1064,0x1065,0x1066.
- Port 4 writes with we_n=0 while only port 4 requests, for 200 cycles -> port 4 is never revoked (burst saturates). SRAM_we_n_o=0 every owned cycle; no rd_valid is generated.
- Resetn pulsed low while 2 reads are in flight -> rd_valid stays 0 afterwards; the state returns to S_IDLE.
